// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update scheduler and its pending-update FIFO.
package btb_pkg;

  localparam int BTB_PC_W        = 32;
  localparam int BTB_ENTRY_COUNT = 16;
  localparam int BTB_IDX_W       = $clog2(BTB_ENTRY_COUNT);
  localparam int BTB_FIFO_DEPTH  = 4;

  typedef struct packed {
    logic [BTB_PC_W-1:0]  pc;
    logic [BTB_PC_W-1:0]  target;
    logic                 taken;
    logic                 hit;
    logic [BTB_IDX_W-1:0] hit_idx;
  } btb_upd_t;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } btb_state_e;

  // Entry indices wrap naturally because ENTRY_COUNT is a power of two.
  function automatic logic [BTB_IDX_W-1:0] btb_idx_inc(input logic [BTB_IDX_W-1:0] idx);
    return idx + BTB_IDX_W'(1);
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Pending-update queue: synchronous FIFO of btb_upd_t with flush and full/empty flags.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = BTB_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  btb_upd_t push_data,
  input  logic     pop,
  input  logic     flush,
  output btb_upd_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  btb_upd_t      mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head      = mem_r[rd_ptr_r[AW-1:0]];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer update; a flush drops everything including a same-cycle push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/btb_update_sched.sv
// Sequences the BTB write port: queued refresh/allocate updates and the invalidate-all sweep.
// Optional statistics counters are built when BTB_UPDATE_SCHED_STATS_EN is defined.
module btb_update_sched
  import btb_pkg::*;
#(
  parameter int TAG_WIDTH   = 32,
  parameter int PC_WIDTH    = BTB_PC_W,
  parameter int ENTRY_COUNT = BTB_ENTRY_COUNT,
  parameter int FIFO_DEPTH  = BTB_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           upd_valid,
  output logic                           upd_ready,
  input  logic [PC_WIDTH-1:0]            upd_pc,
  input  logic [PC_WIDTH-1:0]            upd_target,
  input  logic                           upd_taken,
  input  logic                           upd_hit,
  input  logic [$clog2(ENTRY_COUNT)-1:0] upd_hit_idx,
  input  logic                           inv_req,
  output logic                           inv_busy,
  output logic                           wr_en,
  output logic [$clog2(ENTRY_COUNT)-1:0] wr_idx,
  output logic [TAG_WIDTH-1:0]           wr_tag,
  output logic [PC_WIDTH-1:0]            wr_target,
  output logic                           wr_taken,
  output logic                           wr_valid
`ifdef BTB_UPDATE_SCHED_STATS_EN
  ,
  output logic [31:0]                    stat_alloc_cnt,
  output logic [31:0]                    stat_upd_cnt
`endif
);

  localparam int IDX_W = $clog2(ENTRY_COUNT);

  btb_state_e        state_r;
  logic [IDX_W-1:0]  victim_ptr_r;
  logic [IDX_W-1:0]  sweep_idx_r;
  btb_upd_t          push_data_s;
  btb_upd_t          head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              flush_s;

  assign upd_ready = (state_r == S_IDLE) && !fifo_full_s;
  assign push_s    = upd_valid && upd_ready;
  // A pending invalidate wins over the pop; the queue is discarded instead.
  assign flush_s   = (state_r == S_IDLE) && inv_req;
  assign pop_s     = (state_r == S_IDLE) && !inv_req && !fifo_empty_s;

  assign push_data_s.pc      = upd_pc;
  assign push_data_s.target  = upd_target;
  assign push_data_s.taken   = upd_taken;
  assign push_data_s.hit     = upd_hit;
  assign push_data_s.hit_idx = upd_hit_idx;

  btb_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (flush_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Control FSM and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      victim_ptr_r <= {IDX_W{1'b0}};
      sweep_idx_r  <= {IDX_W{1'b0}};
      inv_busy     <= 1'b0;
      wr_en        <= 1'b0;
      wr_idx       <= {IDX_W{1'b0}};
      wr_tag       <= {TAG_WIDTH{1'b0}};
      wr_target    <= {PC_WIDTH{1'b0}};
      wr_taken     <= 1'b0;
      wr_valid     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (inv_req) begin
            state_r     <= S_SWEEP;
            sweep_idx_r <= {IDX_W{1'b0}};
            inv_busy    <= 1'b1;
          end else if (pop_s) begin
            wr_en     <= 1'b1;
            wr_tag    <= head_s.pc[TAG_WIDTH-1:0];
            wr_target <= head_s.target;
            wr_taken  <= head_s.taken;
            wr_valid  <= 1'b1;
            if (head_s.hit) begin
              wr_idx <= head_s.hit_idx;
            end else begin
              wr_idx       <= victim_ptr_r;
              victim_ptr_r <= btb_idx_inc(victim_ptr_r);
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_SWEEP: begin
          wr_en     <= 1'b1;
          wr_idx    <= sweep_idx_r;
          wr_tag    <= {TAG_WIDTH{1'b0}};
          wr_target <= {PC_WIDTH{1'b0}};
          wr_taken  <= 1'b0;
          wr_valid  <= 1'b0;
          if (sweep_idx_r == IDX_W'(ENTRY_COUNT - 1)) begin
            state_r      <= S_IDLE;
            inv_busy     <= 1'b0;
            victim_ptr_r <= {IDX_W{1'b0}};
          end else begin
            sweep_idx_r <= btb_idx_inc(sweep_idx_r);
          end
        end
        default: begin
          state_r  <= S_IDLE;
          inv_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef BTB_UPDATE_SCHED_STATS_EN
  // Counts only queue-driven writes; sweep writes are excluded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_alloc_cnt <= 32'd0;
      stat_upd_cnt   <= 32'd0;
    end else if (pop_s) begin
      if (head_s.hit) begin
        stat_upd_cnt <= stat_upd_cnt + 32'd1;
      end else begin
        stat_alloc_cnt <= stat_alloc_cnt + 32'd1;
      end
    end else begin
      stat_alloc_cnt <= stat_alloc_cnt;
      stat_upd_cnt   <= stat_upd_cnt;
    end
  end
`endif

endmodule
